// File: rtl/video_pixel_proc.sv
`default_nettype none
// ============================================================================
// video_pixel_proc : per-channel gain/offset/saturate stream processor with
//                    frame-synchronous coefficients; VIDEO_PROC_LINE_CHECK_EN
//                    adds a line-length checker.
// Revision: 1.0
// ============================================================================
module video_pixel_proc #(
    parameter int CH        = 3,
    parameter int BPC       = 8,
    parameter int GAIN_W    = 10,
    parameter int GAIN_FRAC = 8,
    parameter int H_ACTIVE  = 1920,
    parameter int LINE_W    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH*BPC-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic                    in_eol,
    output logic [CH*BPC-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sof,
    output logic                    out_eol,
    input  logic [CH*GAIN_W-1:0]    cfg_gain,
    input  logic [CH*(BPC+1)-1:0]   cfg_offset,
    input  logic                    cfg_bypass,
    input  logic                    cfg_update,
    output logic                    cfg_pending,
    output logic [LINE_W-1:0]       line_cnt,
    output logic [15:0]             frame_cnt,
    input  logic                    err_clr,
    output logic                    err_line_len
);

    localparam int c_O_W = BPC + 1;
    localparam int c_P_W = BPC + GAIN_W;
    localparam int c_R_W = c_P_W + 1 - GAIN_FRAC;
    localparam int c_S_W = ((c_R_W > c_O_W) ? c_R_W : c_O_W) + 1;
    localparam logic [GAIN_W-1:0] c_UNITY = GAIN_W'(1) << GAIN_FRAC;
    localparam logic [c_P_W:0]    c_RND   = (c_P_W + 1)'(1) << (GAIN_FRAC - 1);

    logic w_adv;
    logic w_accept;
    logic w_commit;

    logic [CH*GAIN_W-1:0] r_stg_gain;
    logic [CH*GAIN_W-1:0] r_act_gain;
    logic [CH*c_O_W-1:0]  r_stg_off;
    logic [CH*c_O_W-1:0]  r_act_off;
    logic                 r_stg_byp;
    logic                 r_act_byp;

    logic [CH*GAIN_W-1:0] w_gain;
    logic [CH*c_O_W-1:0]  w_off;
    logic                 w_byp;
    logic [CH*c_P_W-1:0]  w_prod;
    logic [CH*BPC-1:0]    w_res;

    logic                 r_s1_valid;
    logic                 r_s1_sof;
    logic                 r_s1_eol;
    logic                 r_s1_byp;
    logic [CH*BPC-1:0]    r_s1_pix;
    logic [CH*c_P_W-1:0]  r_s1_prod;
    logic [CH*c_O_W-1:0]  r_s1_off;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_commit = w_accept & in_sof & cfg_pending;

    // The committing sof beat must already see the staged coefficients.
    assign w_gain = w_commit ? r_stg_gain : r_act_gain;
    assign w_off  = w_commit ? r_stg_off  : r_act_off;
    assign w_byp  = w_commit ? r_stg_byp  : r_act_byp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_gain  <= {CH{c_UNITY}};
            r_stg_off   <= '0;
            r_stg_byp   <= 1'b0;
            r_act_gain  <= {CH{c_UNITY}};
            r_act_off   <= '0;
            r_act_byp   <= 1'b0;
            cfg_pending <= 1'b0;
        end else begin
            if (cfg_update) begin
                r_stg_gain <= cfg_gain;
                r_stg_off  <= cfg_offset;
                r_stg_byp  <= cfg_bypass;
            end
            if (w_commit) begin
                r_act_gain <= r_stg_gain;
                r_act_off  <= r_stg_off;
                r_act_byp  <= r_stg_byp;
            end
            if (cfg_update) begin
                cfg_pending <= 1'b1;
            end else if (w_commit) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_ch
            logic [c_P_W:0]   w_rnd_sum;
            logic [c_R_W-1:0] w_rnd;
            logic [c_S_W-1:0] w_sum;

            assign w_prod[g*c_P_W +: c_P_W] =
                {{GAIN_W{1'b0}}, in_data[g*BPC +: BPC]} *
                {{BPC{1'b0}}, w_gain[g*GAIN_W +: GAIN_W]};

            assign w_rnd_sum = {1'b0, r_s1_prod[g*c_P_W +: c_P_W]} + c_RND;
            assign w_rnd     = w_rnd_sum[c_P_W:GAIN_FRAC];
            // Two's complement add; the extra headroom bit keeps the sign exact.
            assign w_sum     = {{(c_S_W-c_R_W){1'b0}}, w_rnd} +
                               {{(c_S_W-c_O_W){r_s1_off[g*c_O_W+c_O_W-1]}}, r_s1_off[g*c_O_W +: c_O_W]};

            assign w_res[g*BPC +: BPC] = w_sum[c_S_W-1]         ? {BPC{1'b0}} :
                                         (|w_sum[c_S_W-2:BPC])  ? {BPC{1'b1}} :
                                                                  w_sum[BPC-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_byp   <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_prod  <= '0;
            r_s1_off   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sof   <= in_valid & in_sof;
            r_s1_eol   <= in_valid & in_eol;
            r_s1_byp   <= w_byp;
            r_s1_pix   <= in_data;
            r_s1_prod  <= w_prod;
            r_s1_off   <= w_off;
            out_valid  <= r_s1_valid;
            out_data   <= r_s1_byp ? r_s1_pix : w_res;
            out_sof    <= r_s1_sof;
            out_eol    <= r_s1_eol;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt  <= '0;
            frame_cnt <= '0;
        end else if (w_accept) begin
            if (in_sof) begin
                frame_cnt <= frame_cnt + 16'd1;
                line_cnt  <= in_eol ? LINE_W'(1) : '0;
            end else if (in_eol && (line_cnt != {LINE_W{1'b1}})) begin
                line_cnt <= line_cnt + LINE_W'(1);
            end
        end
    end

`ifdef VIDEO_PROC_LINE_CHECK_EN
    localparam int c_PIX_W = $clog2(H_ACTIVE + 1) + 1;

    logic [c_PIX_W-1:0] r_pix_cnt;
    logic [c_PIX_W-1:0] w_line_pos;
    logic               w_len_bad;

    // The sof beat is itself pixel 0 of the new line.
    assign w_line_pos = in_sof ? '0 : r_pix_cnt;
    assign w_len_bad  = w_accept &
                        ((in_sof & (r_pix_cnt != '0)) |
                         (in_eol & ((w_line_pos + c_PIX_W'(1)) != c_PIX_W'(H_ACTIVE))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt    <= '0;
            err_line_len <= 1'b0;
        end else begin
            if (w_accept) begin
                if (in_eol) begin
                    r_pix_cnt <= '0;
                end else if (in_sof) begin
                    r_pix_cnt <= c_PIX_W'(1);
                end else if (r_pix_cnt != {c_PIX_W{1'b1}}) begin
                    r_pix_cnt <= r_pix_cnt + c_PIX_W'(1);
                end
            end
            if (w_len_bad) begin
                err_line_len <= 1'b1;
            end else if (err_clr) begin
                err_line_len <= 1'b0;
            end
        end
    end
`else
    localparam int c_unused_h_active = H_ACTIVE;
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign err_line_len     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_pixel_proc.sv
`default_nettype none
// ============================================================================
// tb_video_pixel_proc : directed self-checking bench for video_pixel_proc.
// Revision: 1.0
// ============================================================================
module tb_video_pixel_proc;

`ifdef VIDEO_PROC_LINE_CHECK_EN
    localparam logic c_LC = 1'b1;
`else
    localparam logic c_LC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sof;
    logic        out_eol;
    logic [29:0] cfg_gain = {3{10'h100}};
    logic [26:0] cfg_offset = '0;
    logic        cfg_bypass = 1'b0;
    logic        cfg_update = 1'b0;
    logic        cfg_pending;
    logic [11:0] line_cnt;
    logic [15:0] frame_cnt;
    logic        err_clr = 1'b0;
    logic        err_line_len;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic rand_rdy = 1'b0;

    video_pixel_proc dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_eol       (in_eol),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .cfg_gain     (cfg_gain),
        .cfg_offset   (cfg_offset),
        .cfg_bypass   (cfg_bypass),
        .cfg_update   (cfg_update),
        .cfg_pending  (cfg_pending),
        .line_cnt     (line_cnt),
        .frame_cnt    (frame_cnt),
        .err_clr      (err_clr),
        .err_line_len (err_line_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic; cf = {bypass, offsets[26:0], gains[29:0]}.
    function automatic logic [23:0] model_px(input logic [23:0] d, input logic [57:0] cf);
        logic [23:0]       res;
        logic signed [8:0] of;
        int                px, gn, r, s;
        if (cf[57]) return d;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            px = int'(d[8*c +: 8]);
            gn = int'(cf[10*c +: 10]);
            of = cf[30+9*c +: 9];
            r  = (px * gn + 128) / 256;
            s  = r + int'(of);
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            res[8*c +: 8] = 8'(s);
        end
        return res;
    endfunction

    localparam logic [57:0] c_CF_RST = {1'b0, 27'd0, {3{10'h100}}};

    logic [25:0] exp_q[$];
    logic [57:0] m_stg = c_CF_RST;
    logic [57:0] m_act = c_CF_RST;
    logic        m_pending = 1'b0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_out = '0;

    // Scoreboard: model the accepted input, compare every transferred output beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_stg      = c_CF_RST;
            m_act      = c_CF_RST;
            m_pending  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_sof, out_eol, out_data}, prev_out);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("beat", {out_sof, out_eol, out_data}, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_sof, out_eol, out_data};
            if (in_valid && in_ready) begin
                if (in_sof && m_pending) begin
                    m_act     = m_stg;
                    m_pending = 1'b0;
                end
                exp_q.push_back({in_sof, in_eol, model_px(in_data, m_act)});
            end
            if (cfg_update) begin
                m_stg     = {cfg_bypass, cfg_offset, cfg_gain};
                m_pending = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        logic ok;
        ok       = 1'b0;
        in_data  = d;
        in_sof   = s;
        in_eol   = e;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [23:0] exp);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, got, 1);
        if (got) check(tag, out_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [29:0] gn, input logic [26:0] of, input logic by);
        cfg_gain   = gn;
        cfg_offset = of;
        cfg_bypass = by;
        cfg_update = 1'b1;
        @(posedge clk);
        #1;
        cfg_update = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #1;
        idle(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_line", line_cnt, 0);
        check("rst_frame", frame_cnt, 0);
        check("rst_err", err_line_len, 0);
        rst = 1'b0;
        idle(1);

        // Default coefficients, 2-cycle latency, sof&eol counter rule
        send(24'h102030, 1'b0, 1'b0);
        check("t1_lat1_valid", out_valid, 0);
        idle(1);
        check("t1_lat2_valid", out_valid, 1);
        check("t1_lat2_data", out_data, 24'h102030);
        check("t1_line", line_cnt, 0);
        check("t1_frame", frame_cnt, 0);
        send(24'h000001, 1'b1, 1'b1);
        check("t1_sofeol_line", line_cnt, 1);
        check("t1_sofeol_frame", frame_cnt, 1);
        idle(4);

        // Gain 2.0 on ch0, offset -0x20 on ch1; commit at sof
        cfg_write({10'h100, 10'h100, 10'h200}, {9'h000, 9'h1E0, 9'h000}, 1'b0);
        check("t2_pending_set", cfg_pending, 1);
        send(24'h401090, 1'b0, 1'b0);
        wait_out("t2_pre_sof", 24'h401090);
        send(24'h401090, 1'b1, 1'b0);
        check("t2_pending_clr", cfg_pending, 0);
        wait_out("t2_sof", 24'h4000FF);
        send(24'h401090, 1'b0, 1'b1);
        wait_out("t2_post_sof", 24'h4000FF);
        idle(4);

        // Randomised backpressure over 4 full lines
        do_reset();
        cfg_write({10'h0C0, 10'h180, 10'h0C0}, {9'h010, 9'h1FD, 9'h005}, 1'b0);
        rand_rdy = 1'b1;
        for (int ln = 0; ln < 4; ln++) begin
            for (int px = 0; px < 1920; px++) begin
                send(24'($urandom), (ln == 0) && (px == 0), px == 1919);
                if ($urandom_range(0, 7) == 0) idle(1);
            end
        end
        rand_rdy = 1'b0;
        idle(10);
        check("t3_line", line_cnt, 4);
        check("t3_frame", frame_cnt, 1);
        check("t3_drained", exp_q.size(), 0);

        // cfg_update coinciding with the committing sof; rounding of 0x41*0.5
        cfg_write({10'h100, 10'h100, 10'h080}, '0, 1'b0);
        cfg_gain   = {10'h100, 10'h100, 10'h200};
        cfg_update = 1'b1;
        send(24'h101041, 1'b1, 1'b0);
        cfg_update = 1'b0;
        check("t4_pending_kept", cfg_pending, 1);
        wait_out("t4_old_stage", 24'h101021);
        send(24'h101041, 1'b0, 1'b1);
        wait_out("t4_mid_frame", 24'h101021);
        send(24'h101041, 1'b1, 1'b1);
        check("t4_pending_clr", cfg_pending, 0);
        wait_out("t4_new_stage", 24'h101082);
        cfg_write({3{10'h3FF}}, {3{9'h0FF}}, 1'b1);
        send(24'hABCDEF, 1'b1, 1'b1);
        wait_out("t4_bypass", 24'hABCDEF);

        // Line-length checker
        do_reset();
        for (int px = 0; px < 1920; px++) send(24'(px), px == 0, px == 1919);
        check("t5_good_line", err_line_len, 0);
        for (int px = 0; px < 1919; px++) send(24'(px), 1'b0, px == 1918);
        check("t5_short_line", err_line_len, c_LC);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("t5_clear", err_line_len, 0);
        for (int px = 0; px < 5; px++) send(24'(px), 1'b0, 1'b0);
        check("t5_mid", err_line_len, 0);
        err_clr = 1'b1;
        send(24'h000000, 1'b1, 1'b0);
        err_clr = 1'b0;
        check("t5_trunc_sof", err_line_len, c_LC);
        idle(4);

        // Reset with beats in flight
        cfg_write({3{10'h200}}, '0, 1'b0);
        send(24'h010101, 1'b1, 1'b0);
        idle(4);
        send(24'h111111, 1'b0, 1'b0);
        send(24'h222222, 1'b0, 1'b0);
        send(24'h333333, 1'b0, 1'b0);
        check("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_data", out_data, 0);
        idle(1);
        rst = 1'b0;
        begin
            int nv;
            nv = 0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (out_valid) nv++;
            end
            check("t6_no_ghost", nv, 0);
        end
        idle(1);
        check("t6_line", line_cnt, 0);
        check("t6_frame", frame_cnt, 0);
        check("t6_pending", cfg_pending, 0);
        send(24'h102030, 1'b0, 1'b0);
        wait_out("t6_unity_gain", 24'h102030);

        idle(4);
        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
